traffic_phase_ctrl: RTL
=======================

# traffic_phase_ctrl

Parametrised, demand-actuated intersection controller for N_PH signal phases. Each phase has its own car and pedestrian heads. The block serves phases round-robin, skips phases with no demand, and extends green while the served approach still detects traffic. It is the multi-phase successor to the two-sensor TrafficLight controller and keeps its port naming and SIM shortening switch.

## Interface
- N_PH, 4, number of phases (2..8)
- SIM, 1'b0, 1 = one timing tick per CLK; 0 = one tick per CLK_HZ clocks (1 s)
- CLK_HZ, 50_000_000, clock frequency; used only when SIM=0
- GREEN_MIN, 10, minimum green, in ticks
- GREEN_MAX, 30, maximum green when other demand is pending, in ticks
- YELLOW_T, 3, yellow duration, in ticks
- ALLRED_T, 2, all-red clearance, in ticks
- PED_WALK_T, 7, pedestrian walk duration, in ticks; must satisfy PED_WALK_T <= GREEN_MIN

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  synchronous, active-high reset
- CarReq  in  N_PH  car presence sensor per phase, level
- PedReq  in  N_PH  pedestrian push-button per phase, level or pulse
- CarGreen  out  N_PH  green head per phase
- CarYellow  out  N_PH  yellow head per phase
- CarRed  out  N_PH  red head per phase
- PedGreen  out  N_PH  walk per phase
- PedRed  out  N_PH  don't-walk per phase
- PhaseIdx  out  $clog2(N_PH)  phase last served or currently served

## Operation
- Tick generator: with SIM=1, tick=1 every cycle. With SIM=0, a prescaler counts 0..CLK_HZ-1 and asserts tick on wrap. The prescaler clears on RST.
- Demand latches: pend_car[i] sets on CarReq[i]; pend_ped[i] sets on PedReq[i]. Both clear for phase p on the cycle GREEN(p) is entered. If a request arrives in that same cycle, the clear wins. Requests arriving later in the phase re-latch and are served on the next rotation.
- States:
  - ALLRED: timer runs ALLRED_T ticks. It then selects the first pending phase (car or ped) scanning from PhaseIdx+1 mod N_PH. If none is pending, it stays in ALLRED (rest).
  - GREEN(p): the walk flag is captured from pend_ped[p] at entry. If set, PedGreen[p] is asserted for the first PED_WALK_T ticks. Exit to YELLOW on a tick when all of the following hold:
    - timer >= GREEN_MIN
    - any pending request exists for a phase other than p
    - CarReq[p]=0 or timer >= GREEN_MAX
  - With no other demand, GREEN rests indefinitely; the timer saturates at GREEN_MAX.
  - YELLOW(p): runs YELLOW_T ticks, then goes to ALLRED.
- Outputs are a Moore decode of the state register:
  - Exactly one of CarGreen/CarYellow/CarRed is high per phase.
  - PedGreen[i] = ~PedRed[i].
  - A non-served phase is always CarRed/PedRed.
- Timer clears on every state entry and increments on tick.

## Timing
- Reset values (cycle after RST sampled high):
  - state ALLRED, timer 0, all pend 0, PhaseIdx = N_PH-1 (so the first scan starts at 0)
  - CarRed and PedRed all ones; CarGreen, CarYellow, PedGreen all zeros
- RST mid-operation (e.g. during GREEN) forces the reset state on the next edge. Pending demand is lost.
- Request latency: a request sampled at edge k is visible in pend at k+1.
- With SIM=1, YELLOW lasts exactly YELLOW_T cycles and ALLRED exactly ALLRED_T cycles. GREEN lasts at least GREEN_MIN cycles.
- A 1-cycle request pulse is never lost.
- If several phases are pending at the ALLRED decision, the nearest phase after PhaseIdx in round-robin order wins.
- Width rule: the timer is wide enough for max(GREEN_MAX, YELLOW_T, ALLRED_T) and never wraps.

## Structure
- Package traffic_pkg holds:
  - the state enum (ST_ALLRED, ST_GREEN, ST_YELLOW)
  - timer width computation
  - the round-robin next-phase function
- Sub-module tick_gen (parameters SIM, CLK_HZ; ports CLK, RST, tick) is separate so it can be reused by other timed blocks.
- An elaboration-time check fails when PED_WALK_T > GREEN_MIN or N_PH < 2.

## Test plan
All scenarios use N_PH=4, SIM=1, GREEN_MIN=4, GREEN_MAX=10, YELLOW_T=3, ALLRED_T=2, PED_WALK_T=3.
- Reset then no stimulus -> all CarRed=4'b1111, PedRed=4'b1111 held indefinitely. RST pulse mid-GREEN -> same all-red state on the next cycle.
- 1-cycle CarReq[2] pulse -> CarGreen[2] within ALLRED_T+1 cycles, then rests green. Later CarReq[0] pulse -> green holds to 4 cycles total, YELLOW exactly 3 cycles, ALLRED exactly 2 cycles, then CarGreen[0] with PhaseIdx=0.
- CarReq[1] held high during GREEN(1) while pend_car[3]=1 -> green extended to exactly 10 cycles, then YELLOW; phase 1 is re-served after phase 3.
- PedReq[3] pulse with phase 3 idle -> GREEN(3) with PedGreen[3]=1 for exactly 3 cycles, then PedRed[3]=1 while CarGreen[3] remains.
- Simultaneous CarReq=4'b1011 pulses during ALLRED after serving phase 0 -> service order 1, 3, 0.
- SIM=0, CLK_HZ=10 -> tick every 10 cycles. YELLOW lasts exactly 30 cycles.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and helpers for the multi-phase intersection controller.
package traffic_pkg;

   // Controller states
   typedef enum logic [1:0] {
      ST_ALLRED = 2'd0,
      ST_GREEN  = 2'd1,
      ST_YELLOW = 2'd2
   } state_t;

   // Upper bound on phase count; the round-robin scan is unrolled to this size
   localparam int MAX_PH = 8;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

   // Timer must hold the largest per-state tick count without wrapping
   function automatic int timer_width(input int green_max, input int yellow_t,
                                      input int allred_t);
      int m;
      m = max3(green_max, yellow_t, allred_t);
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

   // First set bit of pend scanning from last+1 (mod n_ph); -1 when nothing pending
   function automatic int rr_next(input logic [MAX_PH-1:0] pend, input int last,
                                  input int n_ph);
      int pick;
      int cand;
      pick = -1;
      for (int k = 1; k <= MAX_PH; k++) begin
         if (k <= n_ph) begin
            cand = (last + k) % n_ph;
            if (pick < 0 && pend[3'(cand)]) pick = cand;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/traffic_phase_ctrl_tick_gen.sv
// Timing tick source: every clock in simulation mode, otherwise once per CLK_HZ clocks.
module tick_gen #(
   parameter bit SIM    = 1'b0,
   parameter int CLK_HZ = 50_000_000
) (
   input  logic CLK,
   input  logic RST,
   output logic tick
);

   localparam int CNT_MAX = SIM ? 0 : CLK_HZ - 1;
   localparam int CW      = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == CW'(CNT_MAX));

   // Prescaler wraps to zero on the tick cycle
   always_comb begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
   end

   // Prescaler register, cleared by reset so the first tick is a full period away
   always_ff @(posedge CLK) begin
      if (RST) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Demand-actuated round-robin intersection controller for N_PH phases.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_ALLRED  | clearance interval, then pick next pending phase (rest if none)
// ST_GREEN   | phase_q served green; optional walk for the first PED_WALK_T ticks
// ST_YELLOW  | phase_q served yellow for YELLOW_T ticks
module traffic_phase_ctrl
   import traffic_pkg::*;
#(
   parameter int N_PH       = 4,
   parameter bit SIM        = 1'b0,
   parameter int CLK_HZ     = 50_000_000,
   parameter int GREEN_MIN  = 10,
   parameter int GREEN_MAX  = 30,
   parameter int YELLOW_T   = 3,
   parameter int ALLRED_T   = 2,
   parameter int PED_WALK_T = 7
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [N_PH-1:0]         CarReq,
   input  logic [N_PH-1:0]         PedReq,
   output logic [N_PH-1:0]         CarGreen,
   output logic [N_PH-1:0]         CarYellow,
   output logic [N_PH-1:0]         CarRed,
   output logic [N_PH-1:0]         PedGreen,
   output logic [N_PH-1:0]         PedRed,
   output logic [$clog2(N_PH)-1:0] PhaseIdx
);

   localparam int PW   = $clog2(N_PH);
   localparam int TW   = timer_width(GREEN_MAX, YELLOW_T, ALLRED_T);
   localparam int TMAX = max3(GREEN_MAX, YELLOW_T, ALLRED_T);

   // Timer holds completed ticks; "*_LAST" is the value on the tick that completes the interval
   localparam logic [TW-1:0] GMIN_LAST = TW'(GREEN_MIN - 1);
   localparam logic [TW-1:0] GMAX_LAST = TW'(GREEN_MAX - 1);
   localparam logic [TW-1:0] Y_LAST    = TW'(YELLOW_T - 1);
   localparam logic [TW-1:0] AR_LAST   = TW'(ALLRED_T - 1);
   localparam logic [TW-1:0] WALK_V    = TW'(PED_WALK_T);
   localparam logic [TW-1:0] TMAX_V    = TW'(TMAX);

   generate
      if (N_PH < 2 || N_PH > MAX_PH) begin : g_bad_nph
         $error("traffic_phase_ctrl: N_PH must be in 2..8");
      end
      if (PED_WALK_T > GREEN_MIN) begin : g_bad_walk
         $error("traffic_phase_ctrl: PED_WALK_T must not exceed GREEN_MIN");
      end
      if (GREEN_MIN < 1 || GREEN_MAX < GREEN_MIN || YELLOW_T < 1 || ALLRED_T < 1) begin : g_bad_tim
         $error("traffic_phase_ctrl: timing parameters out of range");
      end
   endgenerate

   logic tick;

   tick_gen #(
      .SIM    (SIM),
      .CLK_HZ (CLK_HZ)
   ) u_tick_gen (
      .CLK  (CLK),
      .RST  (RST),
      .tick (tick)
   );

   state_t          state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [PW-1:0]   phase_q, phase_d;
   logic            walk_q, walk_d;
   logic [N_PH-1:0] pend_car_q, pend_car_d;
   logic [N_PH-1:0] pend_ped_q, pend_ped_d;

   logic [N_PH-1:0] pend_all;
   logic [N_PH-1:0] phase_mask;
   logic            other_dem;
   logic            car_here;
   int              nxt;
   logic            nxt_found;
   logic [PW-1:0]   nxt_idx;

   assign pend_all   = pend_car_q | pend_ped_q;
   assign phase_mask = {{(N_PH-1){1'b0}}, 1'b1} << phase_q;
   assign other_dem  = |(pend_all & ~phase_mask);
   assign car_here   = CarReq[phase_q];

   // Round-robin pick of the next pending phase after the one last served
   always_comb begin
      nxt       = rr_next(MAX_PH'(pend_all), int'(phase_q), N_PH);
      nxt_found = (nxt >= 0);
      nxt_idx   = PW'(nxt);
   end

   // Next-state, demand latches and interval timer
   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      walk_d     = walk_q;
      timer_d    = timer_q;
      pend_car_d = pend_car_q | CarReq;
      pend_ped_d = pend_ped_q | PedReq;

      case (state_q)
         ST_ALLRED: begin
            if (tick && timer_q >= AR_LAST && nxt_found) begin
               state_d = ST_GREEN;
               phase_d = nxt_idx;
               // A walk press landing on the entry edge is honoured here since its latch is cleared
               walk_d  = pend_ped_q[nxt_idx] | PedReq[nxt_idx];
               pend_car_d[nxt_idx] = 1'b0;
               pend_ped_d[nxt_idx] = 1'b0;
            end
         end
         ST_GREEN: begin
            if (tick && timer_q >= GMIN_LAST && other_dem &&
                (!car_here || timer_q >= GMAX_LAST)) begin
               state_d = ST_YELLOW;
            end
         end
         ST_YELLOW: begin
            if (tick && timer_q >= Y_LAST) begin
               state_d = ST_ALLRED;
            end
         end
         default: state_d = ST_ALLRED;
      endcase

      if (state_d != state_q)                 timer_d = '0;
      else if (tick && timer_q < TMAX_V)      timer_d = timer_q + 1'b1;
   end

   // State registers; reset parks on the last phase so the first scan starts at phase 0
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= ST_ALLRED;
         timer_q    <= '0;
         phase_q    <= PW'(N_PH - 1);
         walk_q     <= 1'b0;
         pend_car_q <= '0;
         pend_ped_q <= '0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         phase_q    <= phase_d;
         walk_q     <= walk_d;
         pend_car_q <= pend_car_d;
         pend_ped_q <= pend_ped_d;
      end
   end

   // Moore decode of signal heads; only the served phase can leave red
   always_comb begin
      logic served;
      CarGreen  = '0;
      CarYellow = '0;
      CarRed    = '0;
      PedGreen  = '0;
      PedRed    = '0;
      served    = 1'b0;
      for (int i = 0; i < N_PH; i++) begin
         served       = (phase_q == PW'(i));
         CarGreen[i]  = served && (state_q == ST_GREEN);
         CarYellow[i] = served && (state_q == ST_YELLOW);
         CarRed[i]    = ~(CarGreen[i] | CarYellow[i]);
         PedGreen[i]  = CarGreen[i] && walk_q && (timer_q < WALK_V);
         PedRed[i]    = ~PedGreen[i];
      end
   end

   assign PhaseIdx = phase_q;

endmodule
